// File: rtl/cpu_pkg.sv
// Shared CPU definitions.
// Holds the memory-unit FSM state type, the MemSize encodings, the ALU
// operation type used by the execute stage, and a byte sign-extend helper.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } mau_state_t;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_ops_t;

    function automatic logic [31:0] sext8(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment between the core and a 32-bit Wishbone bus.
// Ports:
//   lane       - byte offset within the word (addr[1:0])
//   size       - SIZE_BYTE / SIZE_WORD
//   store_data - store operand from the core
//   bus_data   - read data from the bus
//   sel        - byte select for the bus
//   lane_data  - store data placed on the bus (byte replicated on all lanes)
//   load_data  - load result (selected byte sign-extended, or whole word)
module mem_lane_align
    import cpu_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic        size,
    input  logic [31:0] store_data,
    input  logic [31:0] bus_data,
    output logic [3:0]  sel,
    output logic [31:0] lane_data,
    output logic [31:0] load_data
);

    logic [7:0] bus_bytes [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign sel[gi]            = (size == SIZE_WORD) || (lane == 2'(gi));
            assign lane_data[gi*8 +: 8] = (size == SIZE_WORD) ? store_data[gi*8 +: 8]
                                                              : store_data[7:0];
            assign bus_bytes[gi]      = bus_data[gi*8 +: 8];
        end
    endgenerate

    assign load_data = (size == SIZE_WORD) ? bus_data : sext8(bus_bytes[lane]);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit bridging the execute stage to a Wishbone classic master.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   req_valid / req_ready - request handshake (ready only when idle)
//   MemRead, MemWrite     - direction (store wins when both set)
//   MemSize               - SIZE_WORD / SIZE_BYTE
//   addr, wdata           - byte address and store data
//   rdata                 - last load result (held between loads)
//   done, err             - completion pulse and its error qualifier
//   wb_*                  - Wishbone classic master signals
module mem_access_unit
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemSize,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mau_state_t       state_reg, state_next;
    logic [CNT_W-1:0] count_reg;
    logic             size_reg;
    logic [1:0]       lane_reg;
    logic             we_reg;
    logic [31:0]      adr_reg;
    logic [31:0]      dat_reg;
    logic [3:0]       sel_reg;
    logic             err_reg;
    logic [31:0]      rdata_reg;

    logic        is_mem;
    logic        misaligned;
    logic        accept;
    logic        go_bus;
    logic        timeout;
    logic [1:0]  align_lane;
    logic        align_size;
    logic [3:0]  align_sel;
    logic [31:0] align_lane_data;
    logic [31:0] align_load_data;

    assign is_mem     = MemRead | MemWrite;
    assign misaligned = (MemSize == SIZE_WORD) && (addr[1:0] != 2'b00);
    assign accept     = (state_reg == ST_IDLE) && req_valid;
    assign go_bus     = is_mem && !misaligned;
    assign timeout    = (count_reg == CNT_LAST);

    // One aligner serves both directions: while idle it shapes the incoming
    // store, during the bus cycle it extracts the load from the captured lane.
    assign align_lane = (state_reg == ST_IDLE) ? addr[1:0] : lane_reg;
    assign align_size = (state_reg == ST_IDLE) ? MemSize   : size_reg;

    mem_lane_align u_align (
        .lane       (align_lane),
        .size       (align_size),
        .store_data (wdata),
        .bus_data   (wb_dat_i),
        .sel        (align_sel),
        .lane_data  (align_lane_data),
        .load_data  (align_load_data)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    state_next = go_bus ? ST_BUS : ST_DONE;
                end
            end
            ST_BUS: begin
                if (wb_ack_i || timeout) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; cyc/stb vanish as soon as reset forces IDLE.
    always_comb begin
        req_ready = (state_reg == ST_IDLE);
        wb_cyc_o  = (state_reg == ST_BUS);
        wb_stb_o  = (state_reg == ST_BUS);
        done      = (state_reg == ST_DONE);
        err       = (state_reg == ST_DONE) && err_reg;
    end

    // Request capture, timeout counter and load-data register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
            size_reg  <= SIZE_BYTE;
            lane_reg  <= 2'b00;
            we_reg    <= 1'b0;
            adr_reg   <= '0;
            dat_reg   <= '0;
            sel_reg   <= '0;
            err_reg   <= 1'b0;
            rdata_reg <= '0;
        end else begin
            if (accept) begin
                err_reg   <= is_mem && misaligned;
                count_reg <= '0;
                if (go_bus) begin
                    size_reg <= MemSize;
                    lane_reg <= addr[1:0];
                    we_reg   <= MemWrite;
                    adr_reg  <= {addr[31:2], 2'b00};
                    dat_reg  <= align_lane_data;
                    sel_reg  <= align_sel;
                end
            end else if (state_reg == ST_BUS) begin
                if (wb_ack_i) begin
                    if (!we_reg) begin
                        rdata_reg <= align_load_data;
                    end
                end else if (timeout) begin
                    err_reg <= 1'b1;
                end else begin
                    count_reg <= count_reg + 1'b1;
                end
            end
        end
    end

    assign rdata    = rdata_reg;
    assign wb_we_o  = we_reg;
    assign wb_adr_o = adr_reg;
    assign wb_dat_o = dat_reg;
    assign wb_sel_o = sel_reg;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max wait cycles for wb_ack_i before abort.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  memory request present from execute stage.
REQ-005 SHALL have port req_ready  output  1  unit idle, request accepted this cycle when req_valid=1.
REQ-006 SHALL have port MemRead  input  1  1: load request.
REQ-007 SHALL have port MemWrite  input  1  1: store request.
REQ-008 SHALL have port MemSize  input  1  1: 32-bit access; 0: 8-bit access.
REQ-009 SHALL have port addr  input  32  byte address, ALU result.
REQ-010 SHALL have port wdata  input  32  store data; byte store uses wdata[7:0].
REQ-011 SHALL have port rdata  output  32  load result, sign-extended for byte loads.
REQ-012 SHALL have port done  output  1  one-cycle pulse at completion (load, store or error).
REQ-013 SHALL have port err  output  1  qualifies done: misaligned word or bus timeout.
REQ-014 SHALL have ports wb_cyc_o, wb_stb_o, wb_we_o  output  1 each  Wishbone classic master control.
REQ-015 SHALL have ports wb_adr_o  output  32, wb_dat_o  output  32, wb_sel_o  output  4  word address (addr[1:0]=0), lane data, byte select.
REQ-016 SHALL have ports wb_dat_i  input  32, wb_ack_i  input  1  slave read data and acknowledge.

Function
REQ-017 SHALL implement FSM states IDLE, BUS, DONE; req_ready=1 only in IDLE.
REQ-018 IDLE: req_valid with MemRead or MemWrite SHALL capture addr/wdata/size/direction and go to BUS next cycle; req_valid with neither SHALL go to DONE with err=0 and no bus cycle.
REQ-019 MemRead and MemWrite both 1 SHALL be treated as store (MemWrite wins).
REQ-020 Word access with addr[1:0]!=0 SHALL go to DONE with err=1, no bus cycle.
REQ-021 BUS: wb_cyc_o=wb_stb_o=1, wb_adr_o={addr[31:2],2'b00}, held stable until ack or timeout.
REQ-022 Byte access: wb_sel_o = 4'b0001 << addr[1:0]; store drives wdata[7:0] replicated on all four lanes; word access wb_sel_o=4'b1111, wb_dat_o=wdata.
REQ-023 wb_ack_i in BUS SHALL end cycle: drop cyc/stb next cycle, register load data, go DONE; latency request-accept to done = 2 cycles when ack is combinational in first BUS cycle.
REQ-024 Byte load: rdata = sign-extend of lane addr[1:0] of wb_dat_i; word load: rdata = wb_dat_i.
REQ-025 A cycle counter SHALL count BUS cycles; reaching TIMEOUT_CYCLES without ack SHALL drop cyc/stb, set err=1, go DONE.
REQ-026 DONE: done=1 for exactly one cycle, then IDLE; rdata SHALL hold its value until next load completes; stores leave rdata unchanged.
REQ-027 wb_ack_i outside BUS SHALL be ignored.
REQ-028 req_valid while not in IDLE SHALL be ignored; requester holds it until req_ready.

Reset
REQ-029 reset SHALL asynchronously force IDLE, counter=0, rdata=0, done=0, err=0, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o=0, wb_dat_o=0, wb_sel_o=0.
REQ-030 reset asserted mid-BUS SHALL drop wb_cyc_o/wb_stb_o immediately, no done pulse for the aborted request.

Structure
REQ-031 FSM state enum, MemSize encodings (SIZE_BYTE=0, SIZE_WORD=1) SHALL live in shared package cpu_pkg alongside alu_ops_t.
REQ-032 Lane select/replicate and sign-extend logic SHALL be a combinational sub-module mem_lane_align.

Verification
REQ-033 Word store addr=0x0000_1000, wdata=0xDEADBEEF, ack in 1st BUS cycle -> sel=1111, we=1, dat=0xDEADBEEF, done at cycle 2, err=0.
REQ-034 Byte load addr=0x0000_2003, wb_dat_i=0x80FF_0102 -> sel=1000, rdata=0xFFFF_FF80.
REQ-035 Byte store addr=0x0000_0001, wdata=0x0000_00A5 -> sel=0010, dat=0xA5A5A5A5.
REQ-036 Word load addr=0x0000_0006 -> no wb_cyc_o, done=1 err=1 one cycle after accept.
REQ-037 Load with ack never asserted, TIMEOUT_CYCLES=4 -> cyc drops after 4 BUS cycles, done=1 err=1.
REQ-038 reset pulsed during BUS wait -> cyc/stb=0 same cycle, no done, req_ready=1 after release.
